fetch_stage: RTL and testbench

- Instruction-fetch stage of the femtoRV32 pipeline, directly upstream of decode (ImmGen, control, register file).
- Owns the PC and issues in-order requests to instruction memory over a valid/ready request channel with a fixed-order response channel.
- Buffers returned words and presents {inst, pc, pc_plus4} to the IF/ID boundary under a valid/ready handshake.
- Handles branch/jump redirects from EX by flushing the buffer and discarding stale in-flight responses.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 35 +++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the femtoRV32 front end: datapath width, the canonical
// NOP word and the opcode field accessor used by decode.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  function automatic logic [6:0] ir_opcode(input logic [XLEN-1:0] ir);
    return ir[6:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel, EX redirect and the IF/ID
// handshake of the fetch stage, bundled as one interface.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_inst, id_pc, id_pc_plus4,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_inst, id_pc, id_pc_plus4,
    output id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a flush input. A push in the flush cycle survives
// as the sole entry, so a request issued alongside a redirect is kept.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0) && !clr;
  assign dout   = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[clr ? '0 : wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// femtoRV32 instruction fetch: owns the PC, issues credit-limited in-order fetches,
// pairs responses with their PC tags and hands {inst, pc, pc+4} to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] NOP_INST        = RV_NOP
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  localparam int            CW      = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW:0]   CREDITS = (CW+1)'(MAX_OUTSTANDING);

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   tag_head;
  logic [2*XLEN-1:0] buf_head;
  logic [CW-1:0]     tag_count;
  logic [CW-1:0]     buf_count;
  logic [CW-1:0]     drop_cnt;
  logic [CW:0]       used;
  logic              armed;
  logic              accept;
  logic              resp_keep;
  logic              pop;

  assign req_addr = bus.redirect_valid ? {bus.redirect_pc[XLEN-1:2], 2'b00} : pc;

  assign bus.id_valid = (buf_count != '0) && !bus.redirect_valid;
  assign pop          = bus.id_valid && bus.id_ready;

  // In flight = kept requests (one tag each) + stale ones awaiting discard.
  // A word leaving the buffer this cycle frees its slot for a new request.
  assign used = (CW+1)'(tag_count) + (CW+1)'(drop_cnt) + (CW+1)'(buf_count)
              - (CW+1)'(pop);

  assign bus.imem_req_valid = armed && (used < CREDITS);
  assign bus.imem_req_addr  = req_addr;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_keep          = bus.imem_resp_valid && (drop_cnt == '0) && !bus.redirect_valid;

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.redirect_valid),
    .push  (accept),
    .din   (req_addr),
    .pop   (resp_keep),
    .dout  (tag_head),
    .count (tag_count)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(MAX_OUTSTANDING)) u_inst_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.redirect_valid),
    .push  (resp_keep),
    .din   ({bus.imem_resp_data, tag_head}),
    .pop   (pop),
    .dout  (buf_head),
    .count (buf_count)
  );

  // NOTE: outputs get their idle values first so no path through this block infers a latch.
  always_comb begin
    bus.id_inst = NOP_INST;
    bus.id_pc   = '0;
    if (bus.id_valid) begin
      bus.id_inst = buf_head[2*XLEN-1:XLEN];
      bus.id_pc   = buf_head[XLEN-1:0];
    end
  end

  assign bus.id_pc_plus4 = bus.id_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      armed    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      armed <= 1'b1;

      if (accept)                  pc <= req_addr + XLEN'(4);
      else if (bus.redirect_valid) pc <= req_addr;

      // Everything in flight at a redirect goes stale, less a response landing now.
      if (bus.redirect_valid)
        drop_cnt <= tag_count + drop_cnt - CW'(bus.imem_resp_valid);
      else if (bus.imem_resp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: 1-cycle in-order instruction memory returning
// addr ^ 32'hC0DE_0000, with a hold control to park responses in flight.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  logic hold;
  int   n_checks;
  int   n_errors;

  logic [31:0] mem_q[$];

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Instruction memory: accepted addresses queue up and return one cycle later, in order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q.delete();
      bus.imem_resp_valid <= 1'b0;
      bus.imem_resp_data  <= '0;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) mem_q.push_back(bus.imem_req_addr);
      bus.imem_resp_valid <= 1'b0;
      if (!hold && mem_q.size() > 0) begin
        bus.imem_resp_valid <= 1'b1;
        bus.imem_resp_data  <= mem_q.pop_front() ^ 32'hC0DE_0000;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.id_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 32'(bus.id_valid), 32'd1);
  endtask

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    rst_n              = 1'b0;
    hold               = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;

    // Reset state
    step();
    step();
    check("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
    check("rst_id_valid",    32'(bus.id_valid),       32'd0);
    check("rst_id_inst",     bus.id_inst,             32'h0000_0013);
    check("rst_id_pc",       bus.id_pc,               32'h0);
    check("rst_id_pc_plus4", bus.id_pc_plus4,         32'h4);

    // Sequential fetch from RESET_PC
    rst_n = 1'b1;
    settle();
    check("first_cycle_no_req", 32'(bus.imem_req_valid), 32'd0);
    step();
    check("req0_valid", 32'(bus.imem_req_valid), 32'd1);
    check("req0_addr",  bus.imem_req_addr,       32'h0);
    step();
    check("req1_addr",   bus.imem_req_addr,  32'h4);
    check("no_early_id", 32'(bus.id_valid),  32'd0);
    step();
    check("id0_valid", 32'(bus.id_valid), 32'd1);
    check("id0_pc",    bus.id_pc,         32'h0);
    check("id0_inst",  bus.id_inst,       32'hC0DE_0000);
    check("id0_plus4", bus.id_pc_plus4,   32'h4);
    step();
    check("id1_pc",    bus.id_pc,         32'h4);
    check("id1_inst",  bus.id_inst,       32'hC0DE_0004);
    check("id1_plus4", bus.id_pc_plus4,   32'h8);
    step();
    check("id2_pc", bus.id_pc, 32'h8);

    // Back-pressure: decode stalls for 5 cycles with pc 8 presented
    bus.id_ready = 1'b0;
    settle();
    check("credits_exhausted", 32'(bus.imem_req_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pc",     bus.id_pc,               32'h8);
      check("stall_valid",  32'(bus.id_valid),       32'd1);
      check("stall_no_req", 32'(bus.imem_req_valid), 32'd0);
    end
    step();
    bus.id_ready = 1'b1;
    hold         = 1'b1;
    settle();
    check("release_pc",       bus.id_pc,               32'h8);
    check("release_req",      32'(bus.imem_req_valid), 32'd1);
    check("release_req_addr", bus.imem_req_addr,       32'h10);
    step();
    check("after_release_pc",   bus.id_pc,         32'hC);
    check("after_release_inst", bus.id_inst,       32'hC0DE_000C);
    check("req_addr_14",        bus.imem_req_addr, 32'h14);

    // Redirect with 0x10 and 0x14 in flight
    step();
    check("drained_id_valid",     32'(bus.id_valid),       32'd0);
    check("two_in_flight_no_req", 32'(bus.imem_req_valid), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    hold               = 1'b0;
    settle();
    check("redir_addr",     bus.imem_req_addr,  32'h100);
    check("redir_id_valid", 32'(bus.id_valid),  32'd0);
    step();
    bus.redirect_valid = 1'b0;
    settle();
    wait_valid("redir1");
    check("redir1_pc",    bus.id_pc,       32'h100);
    check("redir1_inst",  bus.id_inst,     32'hC0DE_0100);
    check("redir1_plus4", bus.id_pc_plus4, 32'h104);
    step();
    check("redir1_next_pc", bus.id_pc, 32'h104);
    step();
    check("redir1_next2_pc", bus.id_pc, 32'h108);

    // Redirect coinciding with a response while decode stalls
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    bus.id_ready       = 1'b0;
    settle();
    check("redir2_id_valid", 32'(bus.id_valid), 32'd0);
    check("redir2_addr",     bus.imem_req_addr, 32'h40);
    step();
    bus.redirect_valid = 1'b0;
    settle();
    check("redir2_no_stale", 32'(bus.id_valid),       32'd0);
    check("redir2_req",      32'(bus.imem_req_valid), 32'd1);
    check("redir2_req_addr", bus.imem_req_addr,       32'h40);
    wait_valid("redir2");
    check("redir2_pc",   bus.id_pc,   32'h40);
    check("redir2_inst", bus.id_inst, 32'hC0DE_0040);
    bus.id_ready = 1'b1;
    step();
    check("redir2_next_pc", bus.id_pc, 32'h44);

    // Misaligned redirect target
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    settle();
    check("misaligned_addr", bus.imem_req_addr, 32'h200);
    step();
    bus.redirect_valid = 1'b0;
    settle();
    wait_valid("misaligned");
    check("misaligned_pc",    bus.id_pc,       32'h200);
    check("misaligned_inst",  bus.id_inst,     32'hC0DE_0200);
    check("misaligned_plus4", bus.id_pc_plus4, 32'h204);

    // PC wrap at the top of the address space
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    settle();
    check("wrap_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    step();
    bus.redirect_valid = 1'b0;
    settle();
    wait_valid("wrap");
    check("wrap_pc",    bus.id_pc,       32'hFFFF_FFFC);
    check("wrap_inst",  bus.id_inst,     32'h3F21_FFFC);
    check("wrap_plus4", bus.id_pc_plus4, 32'h0);
    step();
    check("wrap_next_pc",   bus.id_pc,   32'h0);
    check("wrap_next_inst", bus.id_inst, 32'hC0DE_0000);

    // Asynchronous reset with two requests parked in flight
    hold = 1'b1;
    step();
    step();
    step();
    check("parked_no_req",   32'(bus.imem_req_valid), 32'd0);
    check("parked_id_valid", 32'(bus.id_valid),       32'd0);
    check("pc_before_reset", bus.imem_req_addr,       32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_addr",     bus.imem_req_addr,       32'h0);
    check("async_rst_req",      32'(bus.imem_req_valid), 32'd0);
    check("async_rst_id_valid", 32'(bus.id_valid),       32'd0);
    check("async_rst_inst",     bus.id_inst,             32'h0000_0013);
    check("async_rst_plus4",    bus.id_pc_plus4,         32'h4);
    hold = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    settle();
    check("restart_first_cycle", 32'(bus.imem_req_valid), 32'd0);
    step();
    check("restart_req",      32'(bus.imem_req_valid), 32'd1);
    check("restart_req_addr", bus.imem_req_addr,       32'h0);
    wait_valid("restart");
    check("restart_pc",   bus.id_pc,   32'h0);
    check("restart_inst", bus.id_inst, 32'hC0DE_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
